// File: rtl/mopshub_test_sequencer.sv
// ---------------------------------------------------------------------------
// mopshub_test_sequencer
//
// Sequences the MOPSHUB per-bus test phases (oscillator trim, RX test,
// TX test, custom message) across N_BUSES buses. Each phase raises a level
// output and waits for the matching one-cycle end pulse, or gives up after
// TIMEOUT cycles. Pass and first-error status are recorded for the run.
//
// Optional feature macro: SEQ_LOOP_EN
//   When defined, DONE lasts one cycle and the run restarts automatically
//   while sign_on_sig stays high; error and pass status accumulate across
//   runs and the extra output loop_cnt counts completed runs.
//
// Ports:
//   clk            system clock (40 MHz)
//   rst            asynchronous reset, active low
//   sign_on_sig    start request, rising edge starts a run
//   trim_sig_done  end pulse of the trim phase
//   test_rx_end    end pulse of the RX phase
//   test_tx_end    end pulse of the TX phase
//   costum_msg_end end pulse of the custom-message phase
//   osc_auto_trim  trim phase active
//   test_rx        RX phase active
//   test_tx        TX phase active
//   test_advanced  custom phase active
//   endwait_all    one-cycle pulse at the end of every phase
//   bus_sel        bus under test
//   seq_busy       run in progress
//   seq_done       sequencer in DONE
//   err_flag       sticky: at least one phase timed out
//   err_bus        bus of the first timeout
//   err_phase      phase of the first timeout (0 trim,1 rx,2 tx,3 custom)
//   pass_cnt       completed phases, saturating at 255
//   loop_cnt       completed runs (only with SEQ_LOOP_EN)
// ---------------------------------------------------------------------------
module mopshub_test_sequencer #(
    parameter logic [4:0]  N_BUSES    = 5'd2,
    parameter logic [3:0]  PHASE_MASK = 4'b1111,
    parameter logic [19:0] TIMEOUT    = 20'd500000,
    parameter logic [11:0] GAP_CYCLES = 12'd120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sign_on_sig,
    input  logic        trim_sig_done,
    input  logic        test_rx_end,
    input  logic        test_tx_end,
    input  logic        costum_msg_end,
    output logic        osc_auto_trim,
    output logic        test_rx,
    output logic        test_tx,
    output logic        test_advanced,
    output logic        endwait_all,
    output logic [4:0]  bus_sel,
    output logic        seq_busy,
    output logic        seq_done,
    output logic        err_flag,
    output logic [4:0]  err_bus,
    output logic [1:0]  err_phase,
    output logic [7:0]  pass_cnt
`ifdef SEQ_LOOP_EN
    ,
    output logic [15:0] loop_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PHASE = 3'd1,
        ST_END   = 3'd2,
        ST_GAP   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Last counter value of a phase / gap; a zero setting behaves like one.
    localparam logic [19:0] TO_LAST  = (TIMEOUT == 20'd0) ? 20'd0 : (TIMEOUT - 20'd1);
    localparam logic [11:0] GAP_LAST = (GAP_CYCLES == 12'd0) ? 12'd0 : (GAP_CYCLES - 12'd1);
    localparam logic [4:0]  LAST_BUS = N_BUSES - 5'd1;

    // Lowest set bit of a phase mask as {found, index}.
    function automatic logic [2:0] lowest_phase(input logic [3:0] mask);
        logic [2:0] res;
        casez (mask)
            4'b???1: res = {1'b1, 2'd0};
            4'b??10: res = {1'b1, 2'd1};
            4'b?100: res = {1'b1, 2'd2};
            4'b1000: res = {1'b1, 2'd3};
            default: res = {1'b0, 2'd0};
        endcase
        return res;
    endfunction

    // One-hot phase output vector for a phase index.
    function automatic logic [3:0] phase_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    state_t       state_r;
    logic [1:0]   ptr_r;
    logic [3:0]   phase_act_r;
    logic [19:0]  to_cnt_r;
    logic [11:0]  gap_cnt_r;
    logic         sign_q_r;

    logic         start_s;
    logic [2:0]   first_s;
    logic [2:0]   next_s;
    logic [3:0]   end_v_s;
    logic         end_hit_s;

    // Start-edge detect, phase selection and end-pulse matching.
    always_comb begin
        start_s   = sign_on_sig & ~sign_q_r;
        first_s   = lowest_phase(PHASE_MASK);
        // Only enabled phases strictly above the current pointer qualify.
        next_s    = lowest_phase(PHASE_MASK & (4'b1110 << ptr_r));
        end_v_s   = {costum_msg_end, test_tx_end, test_rx_end, trim_sig_done};
        end_hit_s = end_v_s[ptr_r];
    end

    assign osc_auto_trim = phase_act_r[0];
    assign test_rx       = phase_act_r[1];
    assign test_tx       = phase_act_r[2];
    assign test_advanced = phase_act_r[3];

    // Sequencer FSM with all status outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 2'd0;
            phase_act_r <= 4'd0;
            to_cnt_r    <= 20'd0;
            gap_cnt_r   <= 12'd0;
            sign_q_r    <= 1'b0;
            endwait_all <= 1'b0;
            bus_sel     <= 5'd0;
            seq_busy    <= 1'b0;
            seq_done    <= 1'b0;
            err_flag    <= 1'b0;
            err_bus     <= 5'd0;
            err_phase   <= 2'd0;
            pass_cnt    <= 8'd0;
`ifdef SEQ_LOOP_EN
            loop_cnt    <= 16'd0;
`endif
        end else begin
            sign_q_r    <= sign_on_sig;
            endwait_all <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        // Fresh run: clear all run status.
                        bus_sel   <= 5'd0;
                        err_flag  <= 1'b0;
                        err_bus   <= 5'd0;
                        err_phase <= 2'd0;
                        pass_cnt  <= 8'd0;
                        if (first_s[2]) begin
                            ptr_r       <= first_s[1:0];
                            phase_act_r <= phase_onehot(first_s[1:0]);
                            to_cnt_r    <= 20'd0;
                            seq_busy    <= 1'b1;
                            seq_done    <= 1'b0;
                            state_r     <= ST_PHASE;
                        end else begin
                            // No phase enabled: the run is empty.
                            seq_busy    <= 1'b0;
                            seq_done    <= 1'b1;
                            state_r     <= ST_DONE;
                        end
                    end
`ifdef SEQ_LOOP_EN
                    else if ((state_r == ST_DONE) && sign_on_sig && first_s[2]) begin
                        // Looping: restart at bus 0, keep error and pass status.
                        bus_sel     <= 5'd0;
                        ptr_r       <= first_s[1:0];
                        phase_act_r <= phase_onehot(first_s[1:0]);
                        to_cnt_r    <= 20'd0;
                        seq_busy    <= 1'b1;
                        seq_done    <= 1'b0;
                        state_r     <= ST_PHASE;
                    end
`endif
                    else begin
                        state_r <= state_r;
                    end
                end

                ST_PHASE: begin
                    if (to_cnt_r != 20'hFFFFF) begin
                        to_cnt_r <= to_cnt_r + 20'd1;
                    end else begin
                        to_cnt_r <= to_cnt_r;
                    end
                    // End pulse wins over a timeout in the same cycle.
                    if (end_hit_s) begin
                        if (pass_cnt != 8'hFF) begin
                            pass_cnt <= pass_cnt + 8'd1;
                        end else begin
                            pass_cnt <= pass_cnt;
                        end
                        phase_act_r <= 4'd0;
                        endwait_all <= 1'b1;
                        state_r     <= ST_END;
                    end else if (to_cnt_r >= TO_LAST) begin
                        if (!err_flag) begin
                            err_bus   <= bus_sel;
                            err_phase <= ptr_r;
                        end else begin
                            err_bus   <= err_bus;
                            err_phase <= err_phase;
                        end
                        err_flag    <= 1'b1;
                        phase_act_r <= 4'd0;
                        endwait_all <= 1'b1;
                        state_r     <= ST_END;
                    end else begin
                        state_r <= ST_PHASE;
                    end
                end

                ST_END: begin
                    gap_cnt_r <= 12'd0;
                    if (GAP_CYCLES == 12'd0) begin
                        state_r <= ST_NEXT;
                    end else begin
                        state_r <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_r >= GAP_LAST) begin
                        state_r <= ST_NEXT;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 12'd1;
                    end
                end

                ST_NEXT: begin
                    to_cnt_r <= 20'd0;
                    if (next_s[2]) begin
                        ptr_r       <= next_s[1:0];
                        phase_act_r <= phase_onehot(next_s[1:0]);
                        state_r     <= ST_PHASE;
                    end else if (bus_sel < LAST_BUS) begin
                        bus_sel     <= bus_sel + 5'd1;
                        ptr_r       <= first_s[1:0];
                        phase_act_r <= phase_onehot(first_s[1:0]);
                        state_r     <= ST_PHASE;
                    end else begin
                        seq_busy    <= 1'b0;
                        seq_done    <= 1'b1;
                        state_r     <= ST_DONE;
`ifdef SEQ_LOOP_EN
                        loop_cnt    <= loop_cnt + 16'd1;
`endif
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    phase_act_r <= 4'd0;
                    seq_busy    <= 1'b0;
                    seq_done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mopshub_test_sequencer
//
// Randomised scoreboard bench. For every run the reference model lists the
// phases (bus-major, enabled phases in order), picks a response for each
// (early, random, exactly at timeout, late, none) and derives the expected
// phase length, pass count and first-error record. A responder drives the
// end pulses; a monitor pops expectations at each endwait_all pulse and at
// each rising edge of seq_done.
// ---------------------------------------------------------------------------
module tb_mopshub_test_sequencer;

    localparam int         NB   = 3;
    localparam logic [3:0] MASK = 4'b1101;
    localparam int         TO   = 60;
    localparam int         GAP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sign_on_sig = 1'b0;
    logic trim_sig_done = 1'b0;
    logic test_rx_end = 1'b0;
    logic test_tx_end = 1'b0;
    logic costum_msg_end = 1'b0;

    logic       osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all;
    logic [4:0] bus_sel;
    logic       seq_busy, seq_done, err_flag;
    logic [4:0] err_bus;
    logic [1:0] err_phase;
    logic [7:0] pass_cnt;

    always #5 clk = ~clk;

    mopshub_test_sequencer #(
        .N_BUSES    (5'(NB)),
        .PHASE_MASK (MASK),
        .TIMEOUT    (20'(TO)),
        .GAP_CYCLES (12'(GAP))
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sign_on_sig    (sign_on_sig),
        .trim_sig_done  (trim_sig_done),
        .test_rx_end    (test_rx_end),
        .test_tx_end    (test_tx_end),
        .costum_msg_end (costum_msg_end),
        .osc_auto_trim  (osc_auto_trim),
        .test_rx        (test_rx),
        .test_tx        (test_tx),
        .test_advanced  (test_advanced),
        .endwait_all    (endwait_all),
        .bus_sel        (bus_sel),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .err_flag       (err_flag),
        .err_bus        (err_bus),
        .err_phase      (err_phase),
        .pass_cnt       (pass_cnt)
    );

    typedef struct {
        int bus;
        int phase;
        int len;
        int pcnt;
        int eflag;
    } ph_exp_t;

    typedef struct {
        int pcnt;
        int eflag;
        int ebus;
        int ephase;
    } run_exp_t;

    ph_exp_t  exp_q[$];
    run_exp_t run_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] prev_vec = 4'd0;
    int         len_r    = 0;
    logic       prev_done = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic logic [3:0] pvec();
        return {test_advanced, test_tx, test_rx, osc_auto_trim};
    endfunction

    function automatic int vidx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_ends(input logic [3:0] ev);
        {costum_msg_end, test_tx_end, test_rx_end, trim_sig_done} = ev;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_trim"}, osc_auto_trim, 0);
        chk({pfx, "_rx"}, test_rx, 0);
        chk({pfx, "_tx"}, test_tx, 0);
        chk({pfx, "_adv"}, test_advanced, 0);
        chk({pfx, "_endwait"}, endwait_all, 0);
        chk({pfx, "_bus_sel"}, bus_sel, 0);
        chk({pfx, "_busy"}, seq_busy, 0);
        chk({pfx, "_done"}, seq_done, 0);
        chk({pfx, "_err_flag"}, err_flag, 0);
        chk({pfx, "_err_bus"}, err_bus, 0);
        chk({pfx, "_err_phase"}, err_phase, 0);
        chk({pfx, "_pass_cnt"}, pass_cnt, 0);
    endtask

    // Monitor: phase lengths, end-of-phase status and end-of-run status.
    always @(negedge clk) begin
        logic [3:0] v;
        int nlen;
        ph_exp_t e;
        run_exp_t r;
        v = pvec();
        if (!rst) begin
            prev_vec  <= 4'd0;
            len_r     <= 0;
            prev_done <= 1'b0;
        end else begin
            if (v != 4'd0 && v == prev_vec) nlen = len_r + 1;
            else if (v != 4'd0) nlen = 1;
            else nlen = 0;
            if (v != 4'd0) chk("phase_onehot", $countones(v), 1);
            if (endwait_all) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_endwait", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("end_bus", bus_sel, e.bus);
                    chk("end_phase", vidx(prev_vec), e.phase);
                    chk("phase_len", len_r, e.len);
                    chk("end_pass_cnt", pass_cnt, e.pcnt);
                    chk("end_err_flag", err_flag, e.eflag);
                    chk("end_out_dropped", v, 0);
                end
            end
            if (seq_done && !prev_done) begin
                if (run_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    r = run_q.pop_front();
                    chk("run_pass_cnt", pass_cnt, r.pcnt);
                    chk("run_err_flag", err_flag, r.eflag);
                    chk("run_err_bus", err_bus, r.ebus);
                    chk("run_err_phase", err_phase, r.ephase);
                    chk("run_busy_low", seq_busy, 0);
                    chk("run_pending_phases", exp_q.size(), 0);
                end
            end
            prev_vec  <= v;
            len_r     <= nlen;
            prev_done <= seq_done;
        end
    end

    // Responder for one phase: wait for the output, pulse the end input at
    // offset d (if resp), and pulse the other end inputs once as strays.
    task automatic run_phase(input int p, input int d, input bit resp);
        logic [3:0] v;
        logic [3:0] ev;
        int w;
        int stray_c;
        w = 0;
        v = pvec();
        while (v[p] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
            v = pvec();
        end
        if (v[p] !== 1'b1) begin
            chk("phase_rise_timeout", 0, 1);
            return;
        end
        stray_c = $urandom_range(0, 3);
        for (int c = 0; c <= TO + 1; c++) begin
            v = pvec();
            if (v[p] == 1'b0 && !(resp && c == d)) break;
            ev = 4'd0;
            if (resp && c == d) ev[p] = 1'b1;
            if (c == stray_c && v[p]) ev = ev | (~(4'b0001 << p) & 4'hF);
            set_ends(ev);
            @(negedge clk);
        end
        set_ends(4'd0);
    endtask

    // One full run: model expectations, start edge, responses, wait for DONE.
    task automatic do_run(input int fm, input bit toggle_mid);
        int pl_p[$];
        int pl_d[$];
        bit pl_r[$];
        int pc, ef, eb, ep, k, w;
        ph_exp_t  e;
        run_exp_t r;
        pc = 0; ef = 0; eb = 0; ep = 0; k = 0;
        for (int b = 0; b < NB; b++) begin
            for (int p = 0; p < 4; p++) begin
                if (MASK[p]) begin
                    int m, d;
                    bit resp, pass;
                    m = (fm >= 0) ? ((k + fm) % 10) : int'($urandom_range(0, 9));
                    k++;
                    d = 0; resp = 1'b1;
                    case (m)
                        5: d = TO - 1;          // same cycle as timeout
                        6: d = 0;               // first phase cycle
                        7: resp = 1'b0;         // never answered
                        8: d = TO;              // one cycle too late
                        9: resp = 1'b0;
                        default: d = $urandom_range(1, TO - 2);
                    endcase
                    pass = resp && (d <= TO - 1);
                    if (pass) pc++;
                    else if (ef == 0) begin ef = 1; eb = b; ep = p; end
                    e.bus = b; e.phase = p; e.len = pass ? d + 1 : TO;
                    e.pcnt = pc; e.eflag = ef;
                    exp_q.push_back(e);
                    pl_p.push_back(p); pl_d.push_back(d); pl_r.push_back(resp);
                end
            end
        end
        r.pcnt = pc; r.eflag = ef; r.ebus = eb; r.ephase = ep;
        run_q.push_back(r);
        sign_on_sig = 1'b0;
        @(negedge clk);
        sign_on_sig = 1'b1;
        for (int i = 0; i < pl_p.size(); i++) begin
            run_phase(pl_p[i], pl_d[i], pl_r[i]);
            if (toggle_mid && i == 1) begin
                sign_on_sig = 1'b0;
                @(negedge clk);
                sign_on_sig = 1'b1;
            end
        end
        w = 0;
        while (run_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (run_q.size() != 0) begin
            chk("run_done_timeout", 0, 1);
            run_q.delete();
            exp_q.delete();
        end
    endtask

    initial begin
        ph_exp_t e;
        int w;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", seq_busy, 0);
        chk("idle_done", seq_done, 0);

        do_run(0, 1'b0);        // every response kind once
        do_run(-1, 1'b1);       // start edge while busy must be ignored
        for (int n = 0; n < 3; n++) do_run(-1, 1'b0);

        // Reset in the middle of the bus-0 TX phase.
        e.bus = 0; e.phase = 0; e.len = 6; e.pcnt = 1; e.eflag = 0;
        exp_q.push_back(e);
        sign_on_sig = 1'b0;
        @(negedge clk);
        sign_on_sig = 1'b1;
        run_phase(0, 5, 1'b1);
        w = 0;
        while (test_tx !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("tx_rise_before_reset", test_tx, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_all_zero("midrst");
        exp_q.delete();
        run_q.delete();
        sign_on_sig = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_busy", seq_busy, 0);
        chk("post_rst_pass_cnt", pass_cnt, 0);
        chk("post_rst_trim", osc_auto_trim, 0);

        do_run(-1, 1'b0);       // restarts at bus 0 trim
        do_run(3, 1'b0);
        chk("final_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mopshub_test_sequencer.md
Name: mopshub_test_sequencer

Overview:
Synthesisable, parametrised test sequencer for MOPSHUB bring-up and regression. It runs the per-bus phases oscillator trim, RX test, TX test and custom message in order across N_BUSES buses. Each phase is a start-level/end-pulse handshake with a timeout, and the block records pass and error status. It sits beside data_generator in simulation benches and in FPGA self-test builds, driving that block's test enables.

Parameters:
N_BUSES, 5'd2, number of buses to sequence (1..31); bus index runs 0..N_BUSES-1
PHASE_MASK, 4'b1111, enabled phases: bit0 trim, bit1 rx, bit2 tx, bit3 custom
TIMEOUT, 20'd500000, clk cycles allowed per phase before it is aborted
GAP_CYCLES, 12'd120, idle cycles inserted after each phase (120 cycles = 3 us at 40 MHz)

Ports:
clk  in  1  system clock (40 MHz)
rst  in  1  asynchronous reset, active-low
sign_on_sig  in  1  start request; the rising edge starts a run
trim_sig_done  in  1  end pulse for the trim phase
test_rx_end  in  1  end pulse for the RX phase
test_tx_end  in  1  end pulse for the TX phase
costum_msg_end  in  1  end pulse for the custom-message phase
osc_auto_trim  out  1  trim phase active (level)
test_rx  out  1  RX phase active (level)
test_tx  out  1  TX phase active (level)
test_advanced  out  1  custom phase active (level)
endwait_all  out  1  one-cycle pulse at the end of each phase
bus_sel  out  5  bus under test
seq_busy  out  1  high while a run is in progress
seq_done  out  1  high in DONE
err_flag  out  1  sticky flag: one or more phases timed out during the run
err_bus  out  5  bus of the first timeout
err_phase  out  2  phase of the first timeout (0 trim, 1 rx, 2 tx, 3 custom)
pass_cnt  out  8  count of phases that completed, saturating at 255

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. All outputs are 0. The sign_on_sig edge register is cleared.
- States: IDLE, PHASE, END, GAP, NEXT, DONE. A 2-bit phase pointer selects the current phase.
- IDLE:
  - A rising edge of sign_on_sig (registered previous value 0, current value 1) moves the FSM to PHASE.
  - On entry: bus_sel=0, phase pointer = lowest set bit of PHASE_MASK, err/pass cleared, seq_busy=1.
- PHASE:
  - Exactly one phase output is high; the others are 0. The output rises on the cycle after entry.
  - The timeout counter clears on entry and increments every cycle.
  - Matching end pulse seen: pass_cnt+1 (saturating), go to END.
  - Counter reaches TIMEOUT-1 with no end pulse: phase has timed out. Set err_flag. Load err_bus/err_phase only if err_flag was 0. Go to END.
  - End pulse and timeout in the same cycle: the phase counts as a pass.
  - End pulses for phases that are not active are ignored.
- END:
  - Phase output drops to 0.
  - endwait_all=1 for exactly this one cycle.
  - Go to GAP.
- GAP:
  - Wait GAP_CYCLES cycles, then go to NEXT.
  - GAP_CYCLES=0 goes straight to NEXT.
- NEXT:
  - If an enabled phase remains after the current pointer on this bus: advance the pointer to it and go to PHASE.
  - Else, if bus_sel < N_BUSES-1: bus_sel+1, pointer = first enabled phase, go to PHASE.
  - Else go to DONE.
  - N_BUSES=1: the run covers bus 0 only.
- DONE:
  - seq_done=1, seq_busy=0. err_* and pass_cnt are held.
  - A new sign_on_sig rising edge restarts the run from IDLE entry conditions.
- sign_on_sig edges while seq_busy=1 are ignored.
- PHASE_MASK=0: the start edge goes straight to DONE with pass_cnt=0.
- Reset asserted mid-phase: the phase output drops asynchronously and no endwait_all pulse is generated.
- The timeout counter is 20 bits wide. Counters never wrap.

Optional Feature:
SEQ_LOOP_EN:
- Defined: DONE lasts one cycle, then the run restarts automatically at bus 0 with err_* retained (still first-error-wins) and pass_cnt continuing to count. An extra output loop_cnt[15:0] increments per completed run and wraps at 0xFFFF. sign_on_sig low in DONE stops the loop, and the FSM stays in DONE.
- Not defined: the FSM stops in DONE as described above, and loop_cnt does not exist.

Test Plan:
- Defaults, each end pulse returned 50 cycles after its phase output rises -> 8 phases run in order (bus0 trim, rx, tx, custom; bus1 same); pass_cnt=8; err_flag=0; 8 endwait_all pulses; seq_done=1.
- TIMEOUT=1000, test_tx_end never returned on bus 1 -> test_tx drops after 1000 cycles; err_flag=1, err_bus=1, err_phase=2; run completes with pass_cnt=7.
- PHASE_MASK=4'b0110, N_BUSES=3 -> only test_rx/test_tx asserted; bus_sel steps 0,1,2; pass_cnt=6.
- test_rx_end pulsed on the same cycle the timeout fires -> counts as a pass, err_flag=0; stray costum_msg_end during the RX phase is ignored.
- rst driven low during the bus-0 TX phase -> all outputs 0 immediately; a new sign_on_sig edge restarts at bus 0 trim.
- SEQ_LOOP_EN defined, sign_on_sig held high -> loop_cnt reaches 3 after 3 runs; sign_on_sig dropped -> the FSM stops in DONE.
